// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank with one addressed update port
// (hold/load/shift/rotate/clear/preset), global synchronous reset and
// preset, and two independent registered write-first read ports.
module reg_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             Rs,
    input  logic             Pr,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             sin,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             sout
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROTL = 3'd4,
        OP_ROTR = 3'd5,
        OP_CLR  = 3'd6,
        OP_SET  = 3'd7
    } op_t;

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] regs     [DEPTH];
    logic [WIDTH-1:0] regs_nxt [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] rd_a_nxt;
    logic [WIDTH-1:0] rd_b_nxt;
    logic             sout_nxt;
    logic             addr_ok;
    logic             rda_ok;
    logic             rdb_ok;
    op_t              op_e;

    assign op_e    = op_t'(op);
    assign addr_ok = {1'b0, addr}      < DEPTH_L;
    assign rda_ok  = {1'b0, rd_addr_a} < DEPTH_L;
    assign rdb_ok  = {1'b0, rd_addr_b} < DEPTH_L;

    // Next-state of the bank and sout, ignoring Rs (handled in the register block)
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_nxt[i] = regs[i];
        end
        sout_nxt = sout;
        cur      = '0;
        if (addr_ok) begin
            cur = regs[addr];
        end

        if (Pr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_nxt[i] = '1;
            end
        end else if (addr_ok) begin
            case (op_e)
                OP_HOLD: ;
                OP_LOAD: regs_nxt[addr] = wr_data;
                OP_SHL: begin
                    regs_nxt[addr] = {cur[WIDTH-2:0], sin};
                    sout_nxt       = cur[WIDTH-1];
                end
                OP_SHR: begin
                    regs_nxt[addr] = {sin, cur[WIDTH-1:1]};
                    sout_nxt       = cur[0];
                end
                OP_ROTL: begin
                    regs_nxt[addr] = {cur[WIDTH-2:0], cur[WIDTH-1]};
                    sout_nxt       = cur[WIDTH-1];
                end
                OP_ROTR: begin
                    regs_nxt[addr] = {cur[0], cur[WIDTH-1:1]};
                    sout_nxt       = cur[0];
                end
                OP_CLR:  regs_nxt[addr] = '0;
                OP_SET:  regs_nxt[addr] = '1;
                default: ;
            endcase
        end
    end

    // Write-first read: ports look at the next-state bank, out-of-range reads 0
    always_comb begin
        rd_a_nxt = '0;
        rd_b_nxt = '0;
        if (rda_ok) begin
            rd_a_nxt = regs_nxt[rd_addr_a];
        end
        if (rdb_ok) begin
            rd_b_nxt = regs_nxt[rd_addr_b];
        end
    end

    // State and output registers with synchronous reset taking top priority
    always_ff @(posedge clk) begin
        if (Rs) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            sout      <= 1'b0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= regs_nxt[i];
            end
            sout      <= sout_nxt;
            rd_data_a <= rd_a_nxt;
            rd_data_b <= rd_b_nxt;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: three reg_bank configurations (8x4, 8x3, 16x8) driven with
// directed and random stimulus, checked every cycle against an arithmetic
// reference model plus fixed expected values for the directed steps.
module tb_reg_bank;

    logic clk;

    // Per-instance stimulus (0: W8/D4/AW2, 1: W8/D3/AW2, 2: W16/D8/AW3)
    logic        s_rs   [3];
    logic        s_pr   [3];
    logic [2:0]  s_op   [3];
    logic [2:0]  s_addr [3];
    logic [15:0] s_wd   [3];
    logic        s_sin  [3];
    logic [2:0]  s_ra   [3];
    logic [2:0]  s_rb   [3];

    logic [7:0]  rda0, rdb0, rda1, rdb1;
    logic [15:0] rda2, rdb2;
    logic        so0, so1, so2;

    // Reference model state
    logic [15:0] m_reg  [3][8];
    logic        m_sout [3];
    logic [15:0] m_rda  [3];
    logic [15:0] m_rdb  [3];

    int checks   = 0;
    int failures = 0;

    reg_bank #(.WIDTH(8), .DEPTH(4), .AW(2)) u0 (
        .clk(clk), .Rs(s_rs[0]), .Pr(s_pr[0]), .op(s_op[0]),
        .addr(s_addr[0][1:0]), .wr_data(s_wd[0][7:0]), .sin(s_sin[0]),
        .rd_addr_a(s_ra[0][1:0]), .rd_addr_b(s_rb[0][1:0]),
        .rd_data_a(rda0), .rd_data_b(rdb0), .sout(so0)
    );

    reg_bank #(.WIDTH(8), .DEPTH(3), .AW(2)) u1 (
        .clk(clk), .Rs(s_rs[1]), .Pr(s_pr[1]), .op(s_op[1]),
        .addr(s_addr[1][1:0]), .wr_data(s_wd[1][7:0]), .sin(s_sin[1]),
        .rd_addr_a(s_ra[1][1:0]), .rd_addr_b(s_rb[1][1:0]),
        .rd_data_a(rda1), .rd_data_b(rdb1), .sout(so1)
    );

    reg_bank #(.WIDTH(16), .DEPTH(8), .AW(3)) u2 (
        .clk(clk), .Rs(s_rs[2]), .Pr(s_pr[2]), .op(s_op[2]),
        .addr(s_addr[2]), .wr_data(s_wd[2]), .sin(s_sin[2]),
        .rd_addr_a(s_ra[2]), .rd_addr_b(s_rb[2]),
        .rd_data_a(rda2), .rd_data_b(rdb2), .sout(so2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned tw(input int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic int unsigned td(input int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : 8;
    endfunction

    function automatic int unsigned ta(input int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic logic [15:0] get_rda(input int k);
        return (k == 0) ? {8'h00, rda0} : (k == 1) ? {8'h00, rda1} : rda2;
    endfunction

    function automatic logic [15:0] get_rdb(input int k);
        return (k == 0) ? {8'h00, rdb0} : (k == 1) ? {8'h00, rdb1} : rdb2;
    endfunction

    function automatic logic get_sout(input int k);
        return (k == 0) ? so0 : (k == 1) ? so1 : so2;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model one clock edge of instance k from the bank's arithmetic rules
    task automatic model_step(input int k);
        int unsigned w, d, mask, r, nr, a, si;
        w    = tw(k);
        d    = td(k);
        mask = (32'd1 << w) - 1;
        if (s_rs[k]) begin
            for (int i = 0; i < 8; i++) m_reg[k][i] = 16'h0;
            m_sout[k] = 1'b0;
            m_rda[k]  = 16'h0;
            m_rdb[k]  = 16'h0;
            return;
        end
        if (s_pr[k]) begin
            for (int i = 0; i < 8; i++) if (i < d) m_reg[k][i] = 16'(mask);
        end else if (int'(s_addr[k]) < d) begin
            a  = s_addr[k];
            r  = m_reg[k][a];
            si = s_sin[k] ? 1 : 0;
            nr = r;
            case (s_op[k])
                3'd1: nr = s_wd[k] & mask;
                3'd2: begin nr = ((r * 2) + si) & mask;             m_sout[k] = r >= (mask + 1) / 2; end
                3'd3: begin nr = (r / 2) + si * ((mask + 1) / 2);   m_sout[k] = (r % 2) == 1; end
                3'd4: begin nr = ((r * 2) & mask) + (r >= (mask + 1) / 2 ? 1 : 0); m_sout[k] = r >= (mask + 1) / 2; end
                3'd5: begin nr = (r / 2) + (r % 2) * ((mask + 1) / 2); m_sout[k] = (r % 2) == 1; end
                3'd6: nr = 0;
                3'd7: nr = mask;
                default: ;
            endcase
            m_reg[k][a] = 16'(nr);
        end
        m_rda[k] = (int'(s_ra[k]) < d) ? m_reg[k][s_ra[k]] : 16'h0;
        m_rdb[k] = (int'(s_rb[k]) < d) ? m_reg[k][s_rb[k]] : 16'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_rda%0d", k), get_rda(k), m_rda[k]);
            chk($sformatf("model_rdb%0d", k), get_rdb(k), m_rdb[k]);
            chk($sformatf("model_sout%0d", k), {15'h0, get_sout(k)}, {15'h0, m_sout[k]});
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            s_rs[k] = 1'b0;
            s_pr[k] = 1'b0;
            s_op[k] = 3'd0;
        end
    endtask

    task automatic drv(input int k, input logic [2:0] o, input logic [2:0] a,
                       input logic [15:0] wd, input logic si,
                       input logic [2:0] ra, input logic [2:0] rb);
        s_op[k]   = o;
        s_addr[k] = a;
        s_wd[k]   = wd;
        s_sin[k]  = si;
        s_ra[k]   = ra;
        s_rb[k]   = rb;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            s_rs[k] = 1'b1; s_pr[k] = 1'b0; s_op[k] = 3'd0; s_addr[k] = 3'd0;
            s_wd[k] = 16'h0; s_sin[k] = 1'b0; s_ra[k] = 3'd0; s_rb[k] = 3'd0;
            m_sout[k] = 1'b0; m_rda[k] = 16'h0; m_rdb[k] = 16'h0;
            for (int i = 0; i < 8; i++) m_reg[k][i] = 16'h0;
        end
        tick();
        tick();
        chk("rst_rda", get_rda(0), 16'h0000);
        chk("rst_sout", {15'h0, so0}, 16'h0000);

        // Reset clears a loaded register; Rs wins over Pr
        idle(); drv(0, 3'd1, 3'd2, 16'h00A5, 1'b0, 3'd2, 3'd2); tick();
        chk("load_a5", get_rda(0), 16'h00A5);
        idle(); s_rs[0] = 1'b1; drv(0, 3'd0, 3'd2, 16'h0, 1'b0, 3'd2, 3'd2); tick();
        chk("rst_rda2", get_rda(0), 16'h0000);
        chk("rst_rdb2", get_rdb(0), 16'h0000);
        idle(); s_rs[0] = 1'b1; s_pr[0] = 1'b1; tick();
        chk("rst_pr_rda", get_rda(0), 16'h0000);
        chk("rst_pr_sout", {15'h0, so0}, 16'h0000);
        idle(); drv(0, 3'd0, 3'd2, 16'h0, 1'b0, 3'd2, 3'd1); tick();
        chk("rst_hold_rda", get_rda(0), 16'h0000);

        // Load with same-edge write-first read
        idle(); drv(0, 3'd1, 3'd1, 16'h003C, 1'b0, 3'd1, 3'd0); tick();
        chk("wf_rda", get_rda(0), 16'h003C);
        chk("wf_rdb", get_rdb(0), 16'h0000);

        // Shift/rotate chain on reg0
        idle(); drv(0, 3'd1, 3'd0, 16'h0081, 1'b0, 3'd0, 3'd1); tick();
        chk("chain_load", get_rda(0), 16'h0081);
        idle(); drv(0, 3'd2, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1); tick();
        chk("shl_r", get_rda(0), 16'h0002);
        chk("shl_sout", {15'h0, so0}, 16'h0001);
        idle(); drv(0, 3'd3, 3'd0, 16'h0, 1'b1, 3'd0, 3'd1); tick();
        chk("shr_r", get_rda(0), 16'h0081);
        chk("shr_sout", {15'h0, so0}, 16'h0000);
        idle(); drv(0, 3'd5, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1); tick();
        chk("rotr_r", get_rda(0), 16'h00C0);
        chk("rotr_sout", {15'h0, so0}, 16'h0001);
        idle(); drv(0, 3'd4, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1); tick();
        chk("rotl_r", get_rda(0), 16'h0081);
        chk("rotl_sout", {15'h0, so0}, 16'h0001);
        idle(); drv(0, 3'd1, 3'd0, 16'h00FF, 1'b0, 3'd0, 3'd0); tick();
        chk("load_keeps_sout", {15'h0, so0}, 16'h0001);

        // Preset overrides op, then clear one register
        idle(); s_pr[0] = 1'b1; drv(0, 3'd1, 3'd3, 16'h0000, 1'b0, 3'd3, 3'd0); tick();
        chk("pr_rda", get_rda(0), 16'h00FF);
        chk("pr_rdb", get_rdb(0), 16'h00FF);
        idle(); drv(0, 3'd6, 3'd3, 16'h0, 1'b0, 3'd3, 3'd1); tick();
        chk("clr_r3", get_rda(0), 16'h0000);
        chk("clr_r1", get_rdb(0), 16'h00FF);
        idle(); drv(0, 3'd0, 3'd0, 16'h0, 1'b0, 3'd2, 3'd0); tick();
        chk("clr_r2", get_rda(0), 16'h00FF);
        chk("clr_r0", get_rdb(0), 16'h00FF);

        // Out-of-range address on the DEPTH=3 bank
        idle(); drv(1, 3'd1, 3'd0, 16'h00C0, 1'b0, 3'd0, 3'd0); tick();
        idle(); drv(1, 3'd2, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0); tick();
        chk("oor_pre_sout", {15'h0, so1}, 16'h0001);
        idle(); drv(1, 3'd1, 3'd3, 16'h0055, 1'b0, 3'd3, 3'd0); tick();
        chk("oor_rda", get_rda(1), 16'h0000);
        chk("oor_rdb", get_rdb(1), 16'h0080);
        chk("oor_sout", {15'h0, so1}, 16'h0001);
        idle(); drv(1, 3'd2, 3'd3, 16'h0, 1'b1, 3'd1, 3'd2); tick();
        chk("oor_shl_sout", {15'h0, so1}, 16'h0001);

        // 16-bit / 8-deep bank: rotate a load through the top bit
        idle(); drv(2, 3'd1, 3'd7, 16'h8001, 1'b0, 3'd7, 3'd0); tick();
        chk("p16_load", get_rda(2), 16'h8001);
        idle(); drv(2, 3'd4, 3'd7, 16'h0, 1'b0, 3'd7, 3'd0); tick();
        chk("p16_rotl1", get_rda(2), 16'h0003);
        chk("p16_rotl1_sout", {15'h0, so2}, 16'h0001);
        idle(); drv(2, 3'd4, 3'd7, 16'h0, 1'b0, 3'd7, 3'd0); tick();
        chk("p16_rotl2", get_rda(2), 16'h0006);
        chk("p16_rotl2_sout", {15'h0, so2}, 16'h0000);

        // Random traffic on all three banks against the model
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 3; k++) begin
                s_rs[k]   = ($urandom_range(0, 31) == 0);
                s_pr[k]   = ($urandom_range(0, 19) == 0);
                s_op[k]   = 3'($urandom_range(0, 7));
                s_addr[k] = 3'($urandom_range(0, (1 << ta(k)) - 1));
                s_wd[k]   = 16'($urandom_range(0, (1 << tw(k)) - 1));
                s_sin[k]  = 1'($urandom_range(0, 1));
                s_ra[k]   = 3'($urandom_range(0, (1 << ta(k)) - 1));
                s_rb[k]   = 3'($urandom_range(0, (1 << ta(k)) - 1));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised bank of DEPTH registers, each WIDTH bits wide, replacing single fixed-width bus registers in the datapath.
- One addressed update port with an 8-operation mode set: hold, load, shift left/right, rotate left/right, clear, preset. Global synchronous reset and preset apply to the whole bank.
- Two independent registered read ports feed downstream ALU and bus logic.

Parameters:
WIDTH  8  bits per register (>= 2)
DEPTH  4  number of registers (>= 2)
AW  2  address width; DEPTH <= 2**AW required

Ports:
clk  input  1  clock; all state updates on rising edge
Rs  input  1  reset, synchronous, active-high; clears whole bank
Pr  input  1  synchronous preset, active-high; sets every bit of every register to 1
op  input  3  operation on register[addr]: 0 hold, 1 load, 2 shl, 3 shr, 4 rotl, 5 rotr, 6 clear, 7 preset-one
addr  input  AW  target register for op
wr_data  input  WIDTH  load value for op=1
sin  input  1  serial bit inserted by shl (into LSB) and shr (into MSB)
rd_addr_a  input  AW  read port A address
rd_addr_b  input  AW  read port B address
rd_data_a  output  WIDTH  registered read data, port A
rd_data_b  output  WIDTH  registered read data, port B
sout  output  1  registered bit shifted or rotated out by the last shift/rotate op

Behaviour:
- Priority per edge: Rs > Pr > op.
- Rs=1: all registers, rd_data_a, rd_data_b and sout become 0 on the next edge.
- Rs=0, Pr=1: all registers become all-ones; rd_data_a/rd_data_b become all-ones; sout holds; op is ignored.
- Reset value of every output is 0.
- Otherwise only register[addr] may change; all other registers hold. R = register[addr], W = WIDTH.
  - op=0 (hold): no change.
  - op=1 (load): R <= wr_data.
  - op=2 (shl): R <= {R[W-2:0], sin}; sout <= R[W-1].
  - op=3 (shr): R <= {sin, R[W-1:1]}; sout <= R[0].
  - op=4 (rotl): R <= {R[W-2:0], R[W-1]}; sout <= R[W-1].
  - op=5 (rotr): R <= {R[0], R[W-1:1]}; sout <= R[0].
  - op=6 (clear): R <= 0.
  - op=7 (preset-one): R <= all-ones.
- sout changes only on ops 2-5 and on Rs; every other op leaves it unchanged.
- Address out of range (addr >= DEPTH): op has no effect on any register, and sout holds.
- Read ports:
  - Latency is 1 cycle, write-first.
  - On each edge rd_data_x <= next-state value of register[rd_addr_x], i.e. including the op applied on that same edge.
  - rd_addr_x >= DEPTH returns 0.
  - Ports A and B are fully independent and may address the same register.
- Reset mid-sequence: asserting Rs during any op discards that op. There is no partial-shift state; every op completes in one cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset: with WIDTH=8, DEPTH=4, load 8'hA5 into reg2, then Rs=1 for 1 cycle -> all regs read 8'h00, rd_data_a=rd_data_b=0, sout=0; Rs held together with Pr=1 -> still 0.
- Load + write-first read: op=1, addr=1, wr_data=8'h3C, rd_addr_a=1 on the same edge -> rd_data_a=8'h3C one cycle later; rd_data_b (rd_addr_b=0) stays 8'h00.
- Shift chain: reg0=8'h81; shl with sin=0 -> reg0=8'h02, sout=1; shr with sin=1 -> reg0=8'h81, sout=0; rotr -> reg0=8'hC0, sout=1; rotl -> reg0=8'h81, sout=1.
- Preset priority: Pr=1 with op=1, wr_data=8'h00, addr=3 -> all four regs read 8'hFF; then op=6, addr=3 -> reg3=8'h00, other regs remain 8'hFF.
- Out-of-range: DEPTH=3, AW=2; op=1, addr=3, wr_data=8'h55 -> regs 0-2 unchanged, sout unchanged; rd_addr_a=3 -> rd_data_a=8'h00.
- Parametric: WIDTH=16, DEPTH=8, AW=3; load 16'h8001 into reg7, rotl twice -> reg7=16'h0006, sout=0 after the second rotl (first rotl sets sout=1).
